// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit that fetches, decodes IR[31:27] and steps T-states.
// Latency: one control step per clock; strobes are registered (Moore), branch PC load qualified by CON_FF in T6.
// Backpressure: none; Stop is latched and honoured at the end of the current instruction, HALT exits only on Reset.
// Optional feature macro: CTRL_IO_EN adds the OutPortin strobe and the in/out opcodes.
module control_sequencer #(
  parameter int T_MAX = 7
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic        BAout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  operation,
  output logic        Run,
`ifdef CTRL_IO_EN
  output logic        OutPortin,
`endif
  output logic [3:0]  step
);

  // Step counter is wide enough for T0..T_MAX plus headroom; HALT is reported as 4'hF.
  localparam int SW = $clog2(T_MAX + 2);
  typedef logic [SW-1:0] step_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;

  typedef enum logic [1:0] {PH_START, PH_RUN, PH_HALT} phase_t;

  // One registered bundle of strobes; br_t6 marks the branch step whose PC load waits on CON_FF.
  typedef struct packed {
    logic pcout, zlowout, zhighout, mdrout, hiout, loout, cout, inportout, baout;
    logic marin, zin, pcin, mdrin, irin, yin, hiin, loin, conin;
    logic gra, grb, grc, rin, rout, incpc, read, write;
`ifdef CTRL_IO_EN
    logic outportin;
`endif
    logic br_t6;
    logic [4:0] op;
  } ctrl_t;

  phase_t     phase_q;
  step_t      step_q;
  logic [4:0] opc_q, opc_d;
  logic       stop_q, stop_d;
  ctrl_t      ctrl_q;

  // Opcode bits below the field are decoded by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  function automatic logic legal(input logic [4:0] opc);
    case (opc)
      OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_MUL,
      OP_BR, OP_JR, OP_MFHI, OP_MFLO, OP_NOP: legal = 1'b1;
`ifdef CTRL_IO_EN
      OP_IN, OP_OUT:                          legal = 1'b1;
`endif
      default:                                legal = 1'b0;
    endcase
  endfunction

  function automatic step_t last_step(input logic [4:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: last_step = step_t'(5);
      OP_MUL, OP_BR:                          last_step = step_t'(6);
      OP_LD, OP_ST:                           last_step = step_t'(7);
      default:                                last_step = step_t'(3);
    endcase
  endfunction

  // Strobes for a given step of a given opcode; operation is only non-zero alongside Zin.
  function automatic ctrl_t ctrl_for(input step_t s, input logic [4:0] opc);
    ctrl_t c;
    c = '0;
    case (int'(s))
      0: begin c.pcout = 1'b1; c.marin = 1'b1; c.incpc = 1'b1; c.zin = 1'b1; end
      1: begin c.zlowout = 1'b1; c.pcin = 1'b1; c.read = 1'b1; c.mdrin = 1'b1; end
      2: begin c.mdrout = 1'b1; c.irin = 1'b1; end
      default: begin
        case (opc)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            case (int'(s))
              3: begin c.grb = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
              4: begin
                c.zin = 1'b1;
                if (opc == OP_ADDI) begin c.cout = 1'b1; c.op = OP_ADD; end
                else begin c.grc = 1'b1; c.rout = 1'b1; c.op = opc; end
              end
              5: begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
              default: ;
            endcase
          end
          OP_MUL: begin
            case (int'(s))
              3: begin c.gra = 1'b1; c.rout = 1'b1; c.yin = 1'b1; end
              4: begin c.grb = 1'b1; c.rout = 1'b1; c.zin = 1'b1; c.op = OP_MUL; end
              5: begin c.zlowout = 1'b1; c.loin = 1'b1; end
              6: begin c.zhighout = 1'b1; c.hiin = 1'b1; end
              default: ;
            endcase
          end
          OP_MFHI: if (int'(s) == 3) begin c.hiout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_MFLO: if (int'(s) == 3) begin c.loout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_LD, OP_ST: begin
            case (int'(s))
              3: begin c.grb = 1'b1; c.baout = 1'b1; c.yin = 1'b1; end
              4: begin c.cout = 1'b1; c.zin = 1'b1; c.op = OP_ADD; end
              5: begin c.zlowout = 1'b1; c.marin = 1'b1; end
              6: begin
                c.mdrin = 1'b1;
                if (opc == OP_LD) c.read = 1'b1;
                else begin c.gra = 1'b1; c.rout = 1'b1; end
              end
              7: begin
                if (opc == OP_LD) begin c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
                else c.write = 1'b1;
              end
              default: ;
            endcase
          end
          OP_BR: begin
            case (int'(s))
              3: begin c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1; end
              4: begin c.pcout = 1'b1; c.yin = 1'b1; end
              5: begin c.cout = 1'b1; c.zin = 1'b1; c.op = OP_ADD; end
              6: c.br_t6 = 1'b1;
              default: ;
            endcase
          end
          OP_JR: if (int'(s) == 3) begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; end
`ifdef CTRL_IO_EN
          OP_IN:  if (int'(s) == 3) begin c.inportout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_OUT: if (int'(s) == 3) begin c.gra = 1'b1; c.rout = 1'b1; c.outportin = 1'b1; end
`endif
          default: ;
        endcase
      end
    endcase
    return c;
  endfunction

  // Pending stop accumulates across the instruction; opcode is captured on the T2->T3 edge.
  always_comb begin
    stop_d = stop_q | Stop;
    opc_d  = opc_q;
    if (phase_q == PH_RUN && step_q == step_t'(2)) opc_d = IR[31:27];
  end

  // Sequencer FSM: advances one T-step per clock and registers the strobes of the step being entered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_q <= PH_START;
      step_q  <= '0;
      opc_q   <= '0;
      stop_q  <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      opc_q <= opc_d;
      case (phase_q)
        PH_START: begin
          phase_q <= PH_RUN;
          step_q  <= '0;
          stop_q  <= stop_d;
          ctrl_q  <= ctrl_for('0, opc_q);
        end
        PH_RUN: begin
          if (step_q == step_t'(2) && !legal(opc_d)) begin
            phase_q <= PH_HALT;
            stop_q  <= 1'b0;
            ctrl_q  <= '0;
          end else if (step_q == last_step(opc_q) || step_q == step_t'(T_MAX)) begin
            stop_q <= 1'b0;
            if (stop_d) begin
              phase_q <= PH_HALT;
              ctrl_q  <= '0;
            end else begin
              step_q <= '0;
              ctrl_q <= ctrl_for('0, opc_q);
            end
          end else begin
            step_q <= step_q + step_t'(1);
            stop_q <= stop_d;
            ctrl_q <= ctrl_for(step_q + step_t'(1), opc_d);
          end
        end
        PH_HALT: begin
          ctrl_q <= '0;
          stop_q <= 1'b0;
        end
        default: begin
          phase_q <= PH_HALT;
          ctrl_q  <= '0;
        end
      endcase
    end
  end

  assign PCout     = ctrl_q.pcout;
  assign Zlowout   = ctrl_q.zlowout | (ctrl_q.br_t6 & CON_FF);
  assign ZHighout  = ctrl_q.zhighout;
  assign MDRout    = ctrl_q.mdrout;
  assign HIout     = ctrl_q.hiout;
  assign LOout     = ctrl_q.loout;
  assign Cout      = ctrl_q.cout;
  assign InPortout = ctrl_q.inportout;
  assign BAout     = ctrl_q.baout;
  assign MARin     = ctrl_q.marin;
  assign Zin       = ctrl_q.zin;
  assign PCin      = ctrl_q.pcin | (ctrl_q.br_t6 & CON_FF);
  assign MDRin     = ctrl_q.mdrin;
  assign IRin      = ctrl_q.irin;
  assign Yin       = ctrl_q.yin;
  assign HIin      = ctrl_q.hiin;
  assign LOin      = ctrl_q.loin;
  assign CONin     = ctrl_q.conin;
  assign GRA       = ctrl_q.gra;
  assign GRB       = ctrl_q.grb;
  assign GRC       = ctrl_q.grc;
  assign Rin       = ctrl_q.rin;
  assign Rout      = ctrl_q.rout;
  assign IncPC     = ctrl_q.incpc;
  assign Read      = ctrl_q.read;
  assign Write     = ctrl_q.write;
  assign operation = ctrl_q.op;
`ifdef CTRL_IO_EN
  assign OutPortin = ctrl_q.outportin;
`endif
  assign Run       = (phase_q != PH_HALT);
  assign step      = (phase_q == PH_HALT) ? 4'hF : 4'(step_q);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: table of per-cycle {inputs, expected strobes/op/step/Run}, plus hand sequences.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
// A monitor checks every cycle that at most one bus-source strobe is active.
module tb_control_sequencer;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset, CON_FF, Stop;
  logic [31:0] IR;
  logic PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout, BAout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin;
  logic GRA, GRB, GRC, Rin, Rout, IncPC, Read, Write, Run;
  logic [4:0] operation;
  logic [3:0] step;
`ifdef CTRL_IO_EN
  logic OutPortin;
`endif

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout), .BAout(BAout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .GRA(GRA), .GRB(GRB), .GRC(GRC),
    .Rin(Rin), .Rout(Rout), .IncPC(IncPC), .Read(Read), .Write(Write),
    .operation(operation), .Run(Run),
`ifdef CTRL_IO_EN
    .OutPortin(OutPortin),
`endif
    .step(step)
  );

  logic [25:0] obs;
  assign obs = {Write, Read, IncPC, Rout, Rin, GRC, GRB, GRA, CONin, LOin, HIin, Yin, IRin,
                MDRin, PCin, Zin, MARin, BAout, InPortout, Cout, LOout, HIout, MDRout,
                ZHighout, Zlowout, PCout};

  localparam logic [25:0] M_PCOUT = 26'd1 << 0,  M_ZLOW  = 26'd1 << 1,  M_ZHIGH = 26'd1 << 2;
  localparam logic [25:0] M_MDROUT= 26'd1 << 3,  M_HIOUT = 26'd1 << 4,  M_LOOUT = 26'd1 << 5;
  localparam logic [25:0] M_COUT  = 26'd1 << 6,  M_INPORT= 26'd1 << 7,  M_BAOUT = 26'd1 << 8;
  localparam logic [25:0] M_MARIN = 26'd1 << 9,  M_ZIN   = 26'd1 << 10, M_PCIN  = 26'd1 << 11;
  localparam logic [25:0] M_MDRIN = 26'd1 << 12, M_IRIN  = 26'd1 << 13, M_YIN   = 26'd1 << 14;
  localparam logic [25:0] M_HIIN  = 26'd1 << 15, M_LOIN  = 26'd1 << 16, M_CONIN = 26'd1 << 17;
  localparam logic [25:0] M_GRA   = 26'd1 << 18, M_GRB   = 26'd1 << 19, M_GRC   = 26'd1 << 20;
  localparam logic [25:0] M_RIN   = 26'd1 << 21, M_ROUT  = 26'd1 << 22, M_INCPC = 26'd1 << 23;
  localparam logic [25:0] M_READ  = 26'd1 << 24, M_WRITE = 26'd1 << 25;

  localparam logic [31:0] I_ADD  = 32'h1A920000;  // add R5,R2,R4
  localparam logic [31:0] I_MFLO = 32'hCB000000;  // mflo R6
  localparam logic [31:0] I_MUL  = 32'h78000000;
  localparam logic [31:0] I_LD   = 32'h00000000;
  localparam logic [31:0] I_ST   = 32'h10000000;
  localparam logic [31:0] I_BR   = 32'h90000000;
  localparam logic [31:0] I_JR   = 32'hA0000000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_BAD  = 32'hF8000000;  // opcode 11111
  localparam logic [31:0] I_IN   = 32'hB0000000;
  localparam logic [31:0] I_OUT  = 32'hB8000000;

  typedef struct {
    logic        rst;
    logic [31:0] ir;
    logic        con;
    logic        stop;
    logic [25:0] mask;
    logic [4:0]  op;
    logic [3:0]  stp;
    logic        run;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  task automatic push(input logic rst, input logic [31:0] ir, input logic con, input logic stop,
                      input logic [25:0] m, input logic [4:0] op, input logic [3:0] s, input logic run);
    vec_t v;
    v.rst = rst; v.ir = ir; v.con = con; v.stop = stop;
    v.mask = m; v.op = op; v.stp = s; v.run = run;
    vq.push_back(v);
  endtask

  task automatic ex(input logic [31:0] ir, input logic con, input logic stop,
                    input logic [25:0] m, input logic [4:0] op, input logic [3:0] s);
    push(1'b0, ir, con, stop, m, op, s, 1'b1);
  endtask

  task automatic fetch(input logic [31:0] ir, input logic con);
    ex(ir, con, 1'b0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b00000, 4'd0);
    ex(ir, con, 1'b0, M_ZLOW | M_PCIN | M_READ | M_MDRIN, 5'b00000, 4'd1);
    ex(ir, con, 1'b0, M_MDROUT | M_IRIN, 5'b00000, 4'd2);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic chk_halt(input string name);
    chk({name, ".strobes"}, 32'(obs), 32'h0);
    chk({name, ".step"}, 32'(step), 32'hF);
    chk({name, ".run"}, 32'(Run), 32'h0);
  endtask

  // At most one bus source may drive the bus in any cycle.
  always @(negedge Clock) begin
    if (mon_en) begin
      n_cmp++;
      if ($countones(obs[8:0]) > 1) begin
        n_err++;
        $display("FAIL bus_onehot: bus sources 0x%0h, required at most one bit (t=%0t)", obs[8:0], $time);
      end
    end
  end

  initial begin
    Reset = 1'b1; IR = '0; CON_FF = 1'b0; Stop = 1'b0;

    // Reset held two cycles, then add R5,R2,R4.
    push(1'b1, I_ADD, 1'b0, 1'b0, '0, 5'd0, 4'd0, 1'b1);
    push(1'b1, I_ADD, 1'b0, 1'b0, '0, 5'd0, 4'd0, 1'b1);
    fetch(I_ADD, 1'b0);
    ex(I_ADD, 1'b0, 1'b0, M_GRB | M_ROUT | M_YIN, 5'b00000, 4'd3);
    ex(I_ADD, 1'b0, 1'b0, M_GRC | M_ROUT | M_ZIN, 5'b00011, 4'd4);
    ex(I_ADD, 1'b0, 1'b0, M_ZLOW | M_GRA | M_RIN, 5'b00000, 4'd5);
    // mflo R6: single execute step.
    fetch(I_MFLO, 1'b0);
    ex(I_MFLO, 1'b0, 1'b0, M_LOOUT | M_GRA | M_RIN, 5'b00000, 4'd3);
    // mul: four execute steps, LO then HI.
    fetch(I_MUL, 1'b0);
    ex(I_MUL, 1'b0, 1'b0, M_GRA | M_ROUT | M_YIN, 5'b00000, 4'd3);
    ex(I_MUL, 1'b0, 1'b0, M_GRB | M_ROUT | M_ZIN, 5'b01111, 4'd4);
    ex(I_MUL, 1'b0, 1'b0, M_ZLOW | M_LOIN, 5'b00000, 4'd5);
    ex(I_MUL, 1'b0, 1'b0, M_ZHIGH | M_HIIN, 5'b00000, 4'd6);
    // ld: uses T7.
    fetch(I_LD, 1'b0);
    ex(I_LD, 1'b0, 1'b0, M_GRB | M_BAOUT | M_YIN, 5'b00000, 4'd3);
    ex(I_LD, 1'b0, 1'b0, M_COUT | M_ZIN, 5'b00011, 4'd4);
    ex(I_LD, 1'b0, 1'b0, M_ZLOW | M_MARIN, 5'b00000, 4'd5);
    ex(I_LD, 1'b0, 1'b0, M_READ | M_MDRIN, 5'b00000, 4'd6);
    ex(I_LD, 1'b0, 1'b0, M_MDROUT | M_GRA | M_RIN, 5'b00000, 4'd7);
    // st: Write only in T7.
    fetch(I_ST, 1'b0);
    ex(I_ST, 1'b0, 1'b0, M_GRB | M_BAOUT | M_YIN, 5'b00000, 4'd3);
    ex(I_ST, 1'b0, 1'b0, M_COUT | M_ZIN, 5'b00011, 4'd4);
    ex(I_ST, 1'b0, 1'b0, M_ZLOW | M_MARIN, 5'b00000, 4'd5);
    ex(I_ST, 1'b0, 1'b0, M_GRA | M_ROUT | M_MDRIN, 5'b00000, 4'd6);
    ex(I_ST, 1'b0, 1'b0, M_WRITE, 5'b00000, 4'd7);
    // br not taken, then taken.
    fetch(I_BR, 1'b0);
    ex(I_BR, 1'b0, 1'b0, M_GRA | M_ROUT | M_CONIN, 5'b00000, 4'd3);
    ex(I_BR, 1'b0, 1'b0, M_PCOUT | M_YIN, 5'b00000, 4'd4);
    ex(I_BR, 1'b0, 1'b0, M_COUT | M_ZIN, 5'b00011, 4'd5);
    ex(I_BR, 1'b0, 1'b0, '0, 5'b00000, 4'd6);
    fetch(I_BR, 1'b1);
    ex(I_BR, 1'b1, 1'b0, M_GRA | M_ROUT | M_CONIN, 5'b00000, 4'd3);
    ex(I_BR, 1'b1, 1'b0, M_PCOUT | M_YIN, 5'b00000, 4'd4);
    ex(I_BR, 1'b1, 1'b0, M_COUT | M_ZIN, 5'b00011, 4'd5);
    ex(I_BR, 1'b1, 1'b0, M_ZLOW | M_PCIN, 5'b00000, 4'd6);
    // jr and nop.
    fetch(I_JR, 1'b0);
    ex(I_JR, 1'b0, 1'b0, M_GRA | M_ROUT | M_PCIN, 5'b00000, 4'd3);
    fetch(I_NOP, 1'b0);
    ex(I_NOP, 1'b0, 1'b0, '0, 5'b00000, 4'd3);
    // st aborted by Reset in T6: no Write, step 0, then a clean fetch.
    fetch(I_ST, 1'b0);
    ex(I_ST, 1'b0, 1'b0, M_GRB | M_BAOUT | M_YIN, 5'b00000, 4'd3);
    ex(I_ST, 1'b0, 1'b0, M_COUT | M_ZIN, 5'b00011, 4'd4);
    ex(I_ST, 1'b0, 1'b0, M_ZLOW | M_MARIN, 5'b00000, 4'd5);
    ex(I_ST, 1'b0, 1'b0, M_GRA | M_ROUT | M_MDRIN, 5'b00000, 4'd6);
    push(1'b1, I_ST, 1'b0, 1'b0, '0, 5'd0, 4'd0, 1'b1);
    // add with Stop pulsed during T4: halts after T5.
    fetch(I_ADD, 1'b0);
    ex(I_ADD, 1'b0, 1'b0, M_GRB | M_ROUT | M_YIN, 5'b00000, 4'd3);
    ex(I_ADD, 1'b0, 1'b0, M_GRC | M_ROUT | M_ZIN, 5'b00011, 4'd4);
    ex(I_ADD, 1'b0, 1'b1, M_ZLOW | M_GRA | M_RIN, 5'b00000, 4'd5);
    push(1'b0, I_ADD, 1'b0, 1'b0, '0, 5'd0, 4'hF, 1'b0);
    push(1'b0, I_ADD, 1'b0, 1'b0, '0, 5'd0, 4'hF, 1'b0);
    push(1'b0, I_ADD, 1'b0, 1'b1, '0, 5'd0, 4'hF, 1'b0);

    @(negedge Clock);
    for (int i = 0; i < vq.size(); i++) begin
      Reset = vq[i].rst; IR = vq[i].ir; CON_FF = vq[i].con; Stop = vq[i].stop;
      tick();
      mon_en = 1'b1;
      chk($sformatf("v%0d.strobes", i), 32'(obs), 32'(vq[i].mask));
      chk($sformatf("v%0d.operation", i), 32'(operation), 32'(vq[i].op));
      chk($sformatf("v%0d.step", i), 32'(step), 32'(vq[i].stp));
      chk($sformatf("v%0d.run", i), 32'(Run), 32'(vq[i].run));
    end

    // Opcode 11111 halts at T3 and stays halted for 20 cycles whatever Stop/IR do.
    Reset = 1'b1; Stop = 1'b0; CON_FF = 1'b0; IR = I_BAD;
    tick(); tick();
    Reset = 1'b0;
    tick(); tick(); tick();
    chk("bad_t2.step", 32'(step), 32'd2);
    tick();
    chk_halt("bad_t3");
    for (int k = 0; k < 20; k++) begin
      Stop = k[0];
      IR = I_ADD;
      tick();
      chk_halt($sformatf("bad_hold%0d", k));
    end

    // Port I/O opcodes: executed when the feature is built in, illegal otherwise.
    Reset = 1'b1; Stop = 1'b0; IR = I_IN;
    tick();
    Reset = 1'b0;
    tick(); tick(); tick(); tick();
`ifdef CTRL_IO_EN
    chk("in_t3.strobes", 32'(obs), 32'(M_INPORT | M_GRA | M_RIN));
    tick(); tick(); tick();
    IR = I_OUT;
    tick();
    chk("out_t3.strobes", 32'(obs), 32'(M_GRA | M_ROUT));
    chk("out_t3.outportin", 32'(OutPortin), 32'h1);
    tick();
    chk("out_next.step", 32'(step), 32'd0);
    chk("out_next.outportin", 32'(OutPortin), 32'h0);
`else
    chk_halt("in_illegal");
    Reset = 1'b1; IR = I_OUT;
    tick();
    Reset = 1'b0;
    tick(); tick(); tick(); tick();
    chk_halt("out_illegal");
`endif

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
